// File: rtl/lut_cfg_ctrl_if.sv
// Command / response channel bundle for the LUT configuration sequencer.
//
// Handshake rule for both channels: a transfer happens on a rising clk edge
// where valid and ready are both high. A source holds valid and its payload
// steady until that edge; ready may change freely and has no effect while
// valid is low.
//
// Signals:
//   cmd_valid/cmd_ready  command channel handshake
//   cmd_op               00 WRITE, 01 READ, 10 FILL, 11 CLEAR
//   cmd_addr             start address
//   cmd_len              FILL word count minus 1
//   cmd_data             write data / FILL start value
//   cmd_inc              FILL data increments by 1 per word
//   rsp_valid/rsp_ready  read response handshake
//   rsp_data             captured read data
// master = command issuer / response consumer, slave = controller.
interface lut_cfg_ctrl_if #(
  parameter int ASIZE  = 8,
  parameter int DWIDTH = 16
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [ASIZE-1:0]  cmd_addr;
  logic [ASIZE-1:0]  cmd_len;
  logic [DWIDTH-1:0] cmd_data;
  logic              cmd_inc;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DWIDTH-1:0] rsp_data;

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_len, cmd_data, cmd_inc, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_len, cmd_data, cmd_inc, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/lut_cfg_ctrl.sv
// Configuration sequencer for the lookup table's host port.
// Accepts WRITE / READ / FILL / CLEAR commands, drives the table host pins
// from registers, returns read data on the response channel and marks bulk
// operations with fwd_hold so downstream logic ignores table results.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   cmd_if       command/response channels (lut_cfg_ctrl_if slave)
//   done         one-cycle pulse when WRITE, FILL or CLEAR completes
//   fwd_hold     high on every bulk (FILL/CLEAR) write cycle
//   lut_wren     table host write enable
//   lut_rden     table host read enable
//   lut_addr     table host address (0 when neither enable is high)
//   lut_wdata    table host write data (0 when neither enable is high)
//   lut_rdata    table host read data, combinational from lut_addr
//   state_dbg    current FSM state encoding
module lut_cfg_ctrl #(
  parameter int ASIZE  = 8,
  parameter int DWIDTH = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  lut_cfg_ctrl_if.slave     cmd_if,
  output logic              done,
  output logic              fwd_hold,
  output logic              lut_wren,
  output logic              lut_rden,
  output logic [ASIZE-1:0]  lut_addr,
  output logic [DWIDTH-1:0] lut_wdata,
  input  logic [DWIDTH-1:0] lut_rdata,
  output logic [2:0]        state_dbg
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR   = 3'd1,
    RD   = 3'd2,
    RSP  = 3'd3,
    BULK = 3'd4,
    FIN  = 3'd5
  } state_t;

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_FILL  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  state_t            state;
  logic [ASIZE-1:0]  cnt;       // bulk words remaining after the current one
  logic              inc_q;     // latched FILL increment flag
  logic              rsp_valid;
  logic [DWIDTH-1:0] rsp_data;

  // rst_n is folded in so the command channel reads not-ready for the whole
  // time reset is held, and ready as soon as it is released.
  assign cmd_if.cmd_ready = (state == IDLE) && rst_n;
  assign cmd_if.rsp_valid = rsp_valid;
  assign cmd_if.rsp_data  = rsp_data;
  assign state_dbg        = state;

  // All host-pin outputs are registered: they are loaded on the edge that
  // moves the FSM into the state in which they must be visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      done      <= 1'b0;
      fwd_hold  <= 1'b0;
      lut_wren  <= 1'b0;
      lut_rden  <= 1'b0;
      lut_addr  <= '0;
      lut_wdata <= '0;
      cnt       <= '0;
      inc_q     <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (cmd_if.cmd_valid) begin
            case (cmd_if.cmd_op)
              OP_WRITE: begin
                state     <= WR;
                lut_wren  <= 1'b1;
                lut_addr  <= cmd_if.cmd_addr;
                lut_wdata <= cmd_if.cmd_data;
              end
              OP_READ: begin
                state    <= RD;
                lut_rden <= 1'b1;
                lut_addr <= cmd_if.cmd_addr;
              end
              OP_FILL: begin
                state     <= BULK;
                lut_wren  <= 1'b1;
                fwd_hold  <= 1'b1;
                lut_addr  <= cmd_if.cmd_addr;
                lut_wdata <= cmd_if.cmd_data;
                cnt       <= cmd_if.cmd_len;
                inc_q     <= cmd_if.cmd_inc;
              end
              OP_CLEAR: begin
                // Whole table from address 0 with constant zero data.
                state     <= BULK;
                lut_wren  <= 1'b1;
                fwd_hold  <= 1'b1;
                lut_addr  <= '0;
                lut_wdata <= '0;
                cnt       <= '1;
                inc_q     <= 1'b0;
              end
              default: state <= IDLE;
            endcase
          end
        end
        WR: begin
          lut_wren  <= 1'b0;
          lut_addr  <= '0;
          lut_wdata <= '0;
          done      <= 1'b1;
          state     <= FIN;
        end
        RD: begin
          lut_rden  <= 1'b0;
          lut_addr  <= '0;
          rsp_data  <= lut_rdata;
          rsp_valid <= 1'b1;
          state     <= RSP;
        end
        RSP: begin
          // rsp_data is left as captured; it only changes on the next read.
          if (cmd_if.rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        BULK: begin
          if (cnt == '0) begin
            lut_wren  <= 1'b0;
            fwd_hold  <= 1'b0;
            lut_addr  <= '0;
            lut_wdata <= '0;
            done      <= 1'b1;
            state     <= FIN;
          end else begin
            // Address wraps naturally at 2^ASIZE, data at 2^DWIDTH.
            cnt       <= cnt - 1'b1;
            lut_addr  <= lut_addr + 1'b1;
            lut_wdata <= lut_wdata + DWIDTH'(inc_q);
          end
        end
        FIN: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lut_cfg_ctrl.sv
// Testbench for lut_cfg_ctrl: directed vector table, multi-cycle corner
// sequences, then randomized commands against a table-level reference model.
module tb_lut_cfg_ctrl;

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_FILL  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT ----------------
  lut_cfg_ctrl_if #(.ASIZE(8), .DWIDTH(16)) bus ();
  logic        done, fwd_hold, lut_wren, lut_rden;
  logic [7:0]  lut_addr;
  logic [15:0] lut_wdata, lut_rdata;
  logic [2:0]  state_dbg;

  lut_cfg_ctrl #(.ASIZE(8), .DWIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_if    (bus),
    .done      (done),
    .fwd_hold  (fwd_hold),
    .lut_wren  (lut_wren),
    .lut_rden  (lut_rden),
    .lut_addr  (lut_addr),
    .lut_wdata (lut_wdata),
    .lut_rdata (lut_rdata),
    .state_dbg (state_dbg)
  );

  // Behavioural table behind the host port (resets with the system).
  logic [15:0] lut_mem [256];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) lut_mem[i] <= 16'h0;
    end else if (lut_wren) begin
      lut_mem[lut_addr] <= lut_wdata;
    end
  end
  assign lut_rdata = lut_mem[lut_addr];

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  logic [24:0] exp_q[$];          // {fwd_hold, addr, data} per expected write
  logic [15:0] model_mem [256];   // reference table contents
  int          wr_count = 0;
  int          done_count = 0;
  logic [7:0]  last_wr_addr = 8'h0;
  logic [15:0] last_wr_data = 16'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: expands a command into its write list at table level.
  function automatic void model_writes(input logic [1:0] op, input logic [7:0] addr,
                                       input logic [7:0] len, input logic [15:0] data,
                                       input logic inc);
    int n, a0, d0, a, d;
    bit incr, bulk;
    n = 0; a0 = 0; d0 = 0; incr = 0; bulk = 0;
    case (op)
      OP_WRITE: begin n = 1;           a0 = int'(addr); d0 = int'(data); end
      OP_FILL:  begin n = int'(len)+1; a0 = int'(addr); d0 = int'(data); incr = inc; bulk = 1; end
      OP_CLEAR: begin n = 256;         bulk = 1; end
      default:  n = 0;
    endcase
    for (int i = 0; i < n; i++) begin
      a = (a0 + i) % 256;
      d = incr ? (d0 + i) % 65536 : d0;
      model_mem[a] = 16'(d);
      exp_q.push_back({bulk, 8'(a), 16'(d)});
    end
  endfunction

  // Per-cycle monitor of the host pins.
  always @(negedge clk) begin
    if (rst_n) begin
      check("wr_rd_excl", {31'd0, lut_wren & lut_rden}, 32'd0);
      if (lut_wren) begin
        logic [24:0] e;
        wr_count++;
        last_wr_addr = lut_addr;
        last_wr_data = lut_wdata;
        if (exp_q.size() == 0) begin
          check("unexpected_write", {24'd0, lut_addr}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr",  {24'd0, lut_addr},  {24'd0, e[23:16]});
          check("wr_data",  {16'd0, lut_wdata}, {16'd0, e[15:0]});
          check("fwd_hold", {31'd0, fwd_hold},  {31'd0, e[24]});
        end
      end else begin
        check("fwd_hold_idle", {31'd0, fwd_hold}, 32'd0);
        if (!lut_rden) begin
          check("addr_idle",  {24'd0, lut_addr},  32'd0);
          check("wdata_idle", {16'd0, lut_wdata}, 32'd0);
        end
      end
      if (done) done_count++;
    end
  end

  // ---------------- driver ----------------
  task automatic run_cmd(input logic [1:0] op, input logic [7:0] addr, input logic [7:0] len,
                         input logic [15:0] data, input logic inc, input int hold,
                         input bit pre_ready, output logic [15:0] rdata);
    int n, wc0, dc0, wait_cyc;
    logic [15:0] exp_rd;
    rdata = 16'h0;
    exp_rd = model_mem[addr];
    n = (op == OP_WRITE) ? 1 : (op == OP_FILL) ? int'(len) + 1 : (op == OP_CLEAR) ? 256 : 0;
    model_writes(op, addr, len, data, inc);
    @(negedge clk);
    wait_cyc = 0;
    while (!bus.cmd_ready && wait_cyc < 20) begin
      @(negedge clk);
      wait_cyc++;
    end
    check("cmd_ready_wait", {31'd0, bus.cmd_ready}, 32'd1);
    bus.cmd_op = op; bus.cmd_addr = addr; bus.cmd_len = len;
    bus.cmd_data = data; bus.cmd_inc = inc; bus.cmd_valid = 1'b1;
    bus.rsp_ready = pre_ready;
    wc0 = wr_count; dc0 = done_count;
    @(negedge clk);                       // cycle T+1
    bus.cmd_valid = 1'b0;
    check("cmd_ready_busy", {31'd0, bus.cmd_ready}, 32'd0);
    if (op == OP_READ) begin
      check("rd_rden", {31'd0, lut_rden}, 32'd1);
      check("rd_addr", {24'd0, lut_addr}, {24'd0, addr});
      @(negedge clk);                     // cycle T+2
      check("rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
      check("rsp_data", {16'd0, bus.rsp_data}, {16'd0, exp_rd});
      rdata = bus.rsp_data;
      if (!pre_ready) begin
        for (int k = 0; k < hold; k++) begin
          @(negedge clk);
          check("rsp_hold_valid", {31'd0, bus.rsp_valid}, 32'd1);
          check("rsp_hold_data", {16'd0, bus.rsp_data}, {16'd0, exp_rd});
          check("rsp_hold_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
        end
        bus.rsp_ready = 1'b1;
      end
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      check("rsp_released", {31'd0, bus.rsp_valid}, 32'd0);
      check("rd_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
      check("rd_no_done", done_count - dc0, 32'd0);
    end else begin
      for (int k = 0; k < n; k++) begin
        if (k > 0) @(negedge clk);
        check("wren_run", {31'd0, lut_wren}, 32'd1);
        check("done_early", {31'd0, done}, 32'd0);
      end
      @(negedge clk);                     // cycle T+N+1
      check("done_pulse", {31'd0, done}, 32'd1);
      check("wren_off", {31'd0, lut_wren}, 32'd0);
      @(negedge clk);
      check("done_once", {31'd0, done}, 32'd0);
      check("wr_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
      check("wr_count", wr_count - wc0, n);
      check("exp_q_empty", exp_q.size(), 32'd0);
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [1:0]  op;
    logic [7:0]  addr;
    logic [7:0]  len;
    logic [15:0] data;
    logic        inc;
    int          hold;
    bit          pre_ready;
    int          exp_n;
    logic [7:0]  exp_last_addr;
    logic [15:0] exp_last_data;
    logic [15:0] exp_rdata;
  } vec_t;

  function automatic vec_t mk(logic [1:0] op, logic [7:0] addr, logic [7:0] len,
                              logic [15:0] data, logic inc, int hold, bit pre_ready,
                              int exp_n, logic [7:0] la, logic [15:0] ld, logic [15:0] rd);
    vec_t v;
    v.op = op; v.addr = addr; v.len = len; v.data = data; v.inc = inc;
    v.hold = hold; v.pre_ready = pre_ready; v.exp_n = exp_n;
    v.exp_last_addr = la; v.exp_last_data = ld; v.exp_rdata = rd;
    return v;
  endfunction

  vec_t vecs[13];

  initial begin
    logic [15:0] rd;
    int wc0, dc0, found;

    vecs[0]  = mk(OP_WRITE, 8'h12, 8'h00, 16'hBEEF, 1'b0, 0, 0, 1,   8'h12, 16'hBEEF, 16'h0);
    vecs[1]  = mk(OP_READ,  8'h12, 8'h00, 16'h0000, 1'b0, 0, 0, 0,   8'h00, 16'h0000, 16'hBEEF);
    vecs[2]  = mk(OP_FILL,  8'hFE, 8'h03, 16'h00FF, 1'b1, 0, 0, 4,   8'h01, 16'h0102, 16'h0);
    vecs[3]  = mk(OP_FILL,  8'h10, 8'h01, 16'hFFFF, 1'b1, 0, 0, 2,   8'h11, 16'h0000, 16'h0);
    vecs[4]  = mk(OP_FILL,  8'h20, 8'h01, 16'hFFFF, 1'b0, 0, 0, 2,   8'h21, 16'hFFFF, 16'h0);
    vecs[5]  = mk(OP_FILL,  8'h30, 8'h00, 16'h1234, 1'b1, 0, 0, 1,   8'h30, 16'h1234, 16'h0);
    vecs[6]  = mk(OP_READ,  8'hFF, 8'h00, 16'h0000, 1'b0, 0, 0, 0,   8'h00, 16'h0000, 16'h0100);
    vecs[7]  = mk(OP_CLEAR, 8'h77, 8'h05, 16'hAAAA, 1'b1, 0, 0, 256, 8'hFF, 16'h0000, 16'h0);
    vecs[8]  = mk(OP_READ,  8'hFE, 8'h00, 16'h0000, 1'b0, 0, 0, 0,   8'h00, 16'h0000, 16'h0000);
    vecs[9]  = mk(OP_READ,  8'h01, 8'h00, 16'h0000, 1'b0, 0, 0, 0,   8'h00, 16'h0000, 16'h0000);
    vecs[10] = mk(OP_WRITE, 8'h33, 8'h00, 16'h5A5A, 1'b0, 0, 0, 1,   8'h33, 16'h5A5A, 16'h0);
    vecs[11] = mk(OP_READ,  8'h33, 8'h00, 16'h0000, 1'b0, 5, 0, 0,   8'h00, 16'h0000, 16'h5A5A);
    vecs[12] = mk(OP_READ,  8'h33, 8'h00, 16'h0000, 1'b0, 0, 1, 0,   8'h00, 16'h0000, 16'h5A5A);

    for (int i = 0; i < 256; i++) model_mem[i] = 16'h0;
    bus.cmd_valid = 1'b0; bus.cmd_op = 2'b00; bus.cmd_addr = 8'h0; bus.cmd_len = 8'h0;
    bus.cmd_data = 16'h0; bus.cmd_inc = 1'b0; bus.rsp_ready = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
    check("rst_outputs", {26'd0, done, fwd_hold, lut_wren, lut_rden, bus.rsp_valid, 1'b0}, 32'd0);
    check("rst_addr_data", {8'd0, lut_addr, lut_wdata}, 32'd0);
    check("rst_rsp_data", {16'd0, bus.rsp_data}, 32'd0);
    rst_n = 1'b1;
    #1;
    check("rel_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);

    // Directed vectors
    foreach (vecs[i]) begin
      wc0 = wr_count; dc0 = done_count;
      run_cmd(vecs[i].op, vecs[i].addr, vecs[i].len, vecs[i].data, vecs[i].inc,
              vecs[i].hold, vecs[i].pre_ready, rd);
      if (vecs[i].op == OP_READ) begin
        check("vec_rdata", {16'd0, rd}, {16'd0, vecs[i].exp_rdata});
      end else begin
        check("vec_nwrites", wr_count - wc0, vecs[i].exp_n);
        check("vec_last_addr", {24'd0, last_wr_addr}, {24'd0, vecs[i].exp_last_addr});
        check("vec_last_data", {16'd0, last_wr_data}, {16'd0, vecs[i].exp_last_data});
        check("vec_done_count", done_count - dc0, 32'd1);
      end
    end

    // Randomized commands against the reference model
    for (int r = 0; r < 40; r++) begin
      logic [1:0] op;
      op = 2'($urandom_range(0, 3));
      if (op == OP_CLEAR && $urandom_range(0, 3) != 0) op = OP_FILL;
      run_cmd(op, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 31)),
              16'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)),
              int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), rd);
    end

    // Reset in the middle of a CLEAR
    model_writes(OP_CLEAR, 8'h0, 8'h0, 16'h0, 1'b0);
    @(negedge clk);
    bus.cmd_op = OP_CLEAR; bus.cmd_valid = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    dc0 = done_count;
    found = 0;
    for (int k = 0; k < 300 && found == 0; k++) begin
      if (lut_wren && lut_addr == 8'h40) found = 1;
      else @(negedge clk);
    end
    check("clear_reached_40", found, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_wren", {31'd0, lut_wren}, 32'd0);
    check("mid_rst_hold", {31'd0, fwd_hold}, 32'd0);
    check("mid_rst_done", {31'd0, done}, 32'd0);
    check("mid_rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
    check("mid_rst_remaining", exp_q.size(), 32'd191);
    exp_q.delete();
    for (int i = 0; i < 256; i++) model_mem[i] = 16'h0;
    repeat (2) @(negedge clk);
    check("rst_held_wren", {31'd0, lut_wren}, 32'd0);
    rst_n = 1'b1;
    #1;
    check("rerel_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
    check("mid_rst_no_done", done_count - dc0, 32'd0);
    run_cmd(OP_WRITE, 8'h55, 8'h0, 16'hC0DE, 1'b0, 0, 0, rd);
    run_cmd(OP_READ, 8'h55, 8'h0, 16'h0, 1'b0, 1, 0, rd);
    check("post_rst_read", {16'd0, rd}, 32'h0000_C0DE);
    run_cmd(OP_READ, 8'h41, 8'h0, 16'h0, 1'b0, 0, 0, rd);
    check("post_rst_cleared", {16'd0, rd}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
